alu_op_scheduler: RTL and testbench

- Shares the 4-bit bit-serial ALU between two requesters using round-robin arbitration.
- Latches the winning request's operands, holds the opcode on the ALU for the fixed multi-cycle bit-serial latency, then parks the ALU on the hold opcode and captures result and flags.
- Returns the captured result through a valid/ready response port tagged with the requester ID.
- Sits between the instruction-issue logic and the ALU instance.

---
 rtl/alu_sched_pkg.sv | 25 ++
 rtl/alu_op_scheduler_if.sv | 63 ++++++
 rtl/rr_arbiter2.sv | 22 ++
 rtl/alu_op_scheduler.sv | 140 ++++++++++++++
 tb/tb_alu_op_scheduler.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU operation scheduler: opcodes, FSM encoding and
// the default ALU latency.
package alu_sched_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XNOR = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;

    localparam int DEF_ALU_LAT = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } sched_state_e;

    // Codes above SUB have no ALU meaning and are answered with an error response.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_SUB);
    endfunction

endpackage

// File: rtl/alu_op_scheduler_if.sv
// Bundles the two request ports, the response port and the ALU connection of the
// scheduler; slave is the scheduler's view, master the surrounding logic's view.
interface alu_op_scheduler_if #(parameter int W = 4);

    // Every handshake transfers on a clock edge where VALID and READY are both high;
    // a source holds VALID and its payload stable until that edge, READY may depend
    // combinationally on VALID, and VALID never waits on READY.
    logic         REQ0_VALID;
    logic         REQ0_READY;
    logic [W-1:0] REQ0_A;
    logic [W-1:0] REQ0_B;
    logic [2:0]   REQ0_OP;

    logic         REQ1_VALID;
    logic         REQ1_READY;
    logic [W-1:0] REQ1_A;
    logic [W-1:0] REQ1_B;
    logic [2:0]   REQ1_OP;

    logic         RSP_VALID;
    logic         RSP_READY;
    logic         RSP_ID;
    logic [W-1:0] RSP_C;
    logic         RSP_ZF;
    logic         RSP_SF;
    logic         RSP_CF;
    logic         RSP_ERR;

    logic [W-1:0] ALU_A;
    logic [W-1:0] ALU_B;
    logic [2:0]   ALU_OPCODE;
    logic [W-1:0] ALU_C;
    logic         ALU_ZF;
    logic         ALU_SF;
    logic         ALU_CF;

    logic         BUSY;

    modport slave (
        input  REQ0_VALID, REQ0_A, REQ0_B, REQ0_OP,
        output REQ0_READY,
        input  REQ1_VALID, REQ1_A, REQ1_B, REQ1_OP,
        output REQ1_READY,
        output RSP_VALID, RSP_ID, RSP_C, RSP_ZF, RSP_SF, RSP_CF, RSP_ERR,
        input  RSP_READY,
        output ALU_A, ALU_B, ALU_OPCODE,
        input  ALU_C, ALU_ZF, ALU_SF, ALU_CF,
        output BUSY
    );

    modport master (
        output REQ0_VALID, REQ0_A, REQ0_B, REQ0_OP,
        input  REQ0_READY,
        output REQ1_VALID, REQ1_A, REQ1_B, REQ1_OP,
        input  REQ1_READY,
        input  RSP_VALID, RSP_ID, RSP_C, RSP_ZF, RSP_SF, RSP_CF, RSP_ERR,
        output RSP_READY,
        input  ALU_A, ALU_B, ALU_OPCODE,
        output ALU_C, ALU_ZF, ALU_SF, ALU_CF,
        input  BUSY
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic; the last-grant pointer is owned by the caller.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                // Contention: the requester that did not win last time goes first.
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one multi-cycle bit-serial ALU between two requesters: arbitrates, holds the
// opcode on the ALU for ALU_LAT cycles, captures result/flags and returns them tagged.
module alu_op_scheduler
    import alu_sched_pkg::*;
#(
    parameter int W       = 4,
    parameter int ALU_LAT = DEF_ALU_LAT,
    parameter int CNT_W   = 3
) (
    input  logic               CLK,
    input  logic               RST,
    alu_op_scheduler_if.slave  bus,
    output sched_state_e       dbg_state
);

    sched_state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic             last_grant_q;
    logic [W-1:0]     a_q, b_q;
    logic [2:0]       op_q;
    logic             id_q;
    logic [W-1:0]     rsp_c_q;
    logic             rsp_zf_q, rsp_sf_q, rsp_cf_q, rsp_err_q;

    logic [1:0]   grant;
    logic         accept;
    logic         acc_id;
    logic [W-1:0] acc_a, acc_b;
    logic [2:0]   acc_op;
    logic         cnt_last;

    // Reset also masks READY so nothing can be accepted while RST is low.
    rr_arbiter2 u_arb (
        .req        ({bus.REQ1_VALID, bus.REQ0_VALID}),
        .last_grant (last_grant_q),
        .enable     ((state_q == ST_IDLE) && RST),
        .grant      (grant)
    );

    assign accept   = |grant;
    assign acc_id   = grant[1];
    assign acc_a    = acc_id ? bus.REQ1_A  : bus.REQ0_A;
    assign acc_b    = acc_id ? bus.REQ1_B  : bus.REQ0_B;
    assign acc_op   = acc_id ? bus.REQ1_OP : bus.REQ0_OP;
    assign cnt_last = (cnt_q == CNT_W'(ALU_LAT - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_is_legal(acc_op) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                if (cnt_last) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP: begin
                if (bus.RSP_READY) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_HOLD;
            id_q         <= 1'b0;
            rsp_c_q      <= '0;
            rsp_zf_q     <= 1'b0;
            rsp_sf_q     <= 1'b0;
            rsp_cf_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        a_q          <= acc_a;
                        b_q          <= acc_b;
                        op_q         <= acc_op;
                        id_q         <= acc_id;
                        last_grant_q <= acc_id;
                        cnt_q        <= '0;
                        // Illegal opcodes skip the ALU and answer with a zeroed error response.
                        if (!op_is_legal(acc_op)) begin
                            rsp_c_q   <= '0;
                            rsp_zf_q  <= 1'b0;
                            rsp_sf_q  <= 1'b0;
                            rsp_cf_q  <= 1'b0;
                            rsp_err_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                end
                ST_CAPTURE: begin
                    rsp_c_q   <= bus.ALU_C;
                    rsp_zf_q  <= bus.ALU_ZF;
                    rsp_sf_q  <= bus.ALU_SF;
                    rsp_cf_q  <= bus.ALU_CF;
                    rsp_err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.REQ0_READY = grant[0];
    assign bus.REQ1_READY = grant[1];

    assign bus.RSP_VALID  = (state_q == ST_RESP);
    assign bus.RSP_ID     = id_q;
    assign bus.RSP_C      = rsp_c_q;
    assign bus.RSP_ZF     = rsp_zf_q;
    assign bus.RSP_SF     = rsp_sf_q;
    assign bus.RSP_CF     = rsp_cf_q;
    assign bus.RSP_ERR    = rsp_err_q;

    // The ALU only sees a live opcode while issuing; everywhere else it is parked.
    assign bus.ALU_A      = a_q;
    assign bus.ALU_B      = b_q;
    assign bus.ALU_OPCODE = (state_q == ST_ISSUE) ? op_q : OP_HOLD;

    assign bus.BUSY       = (state_q != ST_IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler: a default-latency instance and an ALU_LAT=1
// instance, each driving a small behavioural ALU that holds its result on opcode 000.
module tb_alu_op_scheduler;
    import alu_sched_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    alu_op_scheduler_if #(.W(4)) bif ();
    alu_op_scheduler_if #(.W(4)) bif1 ();
    sched_state_e st, st1;

    alu_op_scheduler #(.W(4), .ALU_LAT(5), .CNT_W(3)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bif.slave),
        .dbg_state (st)
    );

    alu_op_scheduler #(.W(4), .ALU_LAT(1), .CNT_W(1)) u_dut1 (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bif1.slave),
        .dbg_state (st1)
    );

    function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'b001:  return {1'b0, a ^ b};
            3'b010:  return {1'b0, a} + {1'b0, b};
            3'b011:  return {1'b0, ~(a ^ b)};
            3'b100:  return {1'b0, a} + {1'b0, ~b} + 5'd1;
            default: return 5'd0;
        endcase
    endfunction

    logic [3:0] alu_c_r  = 4'd0;
    logic       alu_cf_r = 1'b0;
    logic [3:0] alu1_c_r  = 4'd0;
    logic       alu1_cf_r = 1'b0;

    always @(posedge CLK) begin
        if (bif.ALU_OPCODE != OP_HOLD) {alu_cf_r, alu_c_r} <= alu_f(bif.ALU_OPCODE, bif.ALU_A, bif.ALU_B);
        if (bif1.ALU_OPCODE != OP_HOLD) {alu1_cf_r, alu1_c_r} <= alu_f(bif1.ALU_OPCODE, bif1.ALU_A, bif1.ALU_B);
    end

    assign bif.ALU_C   = alu_c_r;
    assign bif.ALU_ZF  = (alu_c_r == 4'd0);
    assign bif.ALU_SF  = alu_c_r[3];
    assign bif.ALU_CF  = alu_cf_r;
    assign bif1.ALU_C  = alu1_c_r;
    assign bif1.ALU_ZF = (alu1_c_r == 4'd0);
    assign bif1.ALU_SF = alu1_c_r[3];
    assign bif1.ALU_CF = alu1_cf_r;

    int checks = 0;
    int errors = 0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req0(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bif.REQ0_VALID = v; bif.REQ0_OP = op; bif.REQ0_A = a; bif.REQ0_B = b;
    endtask

    task automatic drive_req1(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bif.REQ1_VALID = v; bif.REQ1_OP = op; bif.REQ1_A = a; bif.REQ1_B = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        logic saw;
        logic stable;
        logic [6:0] exp_v;

        drive_req0(1'b0, 3'b000, 4'h0, 4'h0);
        drive_req1(1'b0, 3'b000, 4'h0, 4'h0);
        bif.RSP_READY   = 1'b0;
        bif1.REQ0_VALID = 1'b0; bif1.REQ0_OP = 3'b000; bif1.REQ0_A = 4'h0; bif1.REQ0_B = 4'h0;
        bif1.REQ1_VALID = 1'b0; bif1.REQ1_OP = 3'b000; bif1.REQ1_A = 4'h0; bif1.REQ1_B = 4'h0;
        bif1.RSP_READY  = 1'b0;

        // Reset: a requester already waiting must not see READY.
        bif.REQ0_VALID = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        check("rst_state",  32'(st), 32'(ST_IDLE));
        check("rst_ready0", 32'(bif.REQ0_READY), 32'd0);
        check("rst_valid",  32'(bif.RSP_VALID), 32'd0);
        check("rst_opcode", 32'(bif.ALU_OPCODE), 32'd0);
        check("rst_busy",   32'(bif.BUSY), 32'd0);
        check("rst_alu_a",  32'(bif.ALU_A), 32'd0);
        bif.REQ0_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;

        // ADD 3+5 from requester 0.
        @(negedge CLK);
        drive_req0(1'b1, OP_ADD, 4'd3, 4'd5);
        #1;
        check("add_ready0", 32'(bif.REQ0_READY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bif.REQ0_VALID = 1'b0;
        lat = 1;
        n = 0;
        while (bif.ALU_OPCODE == OP_ADD && n < 10) begin
            n++;
            @(negedge CLK);
            lat++;
        end
        check("add_issue_len", 32'(n), 32'd5);
        check("add_op_hold",   32'(bif.ALU_OPCODE), 32'(OP_HOLD));
        check("add_busy",      32'(bif.BUSY), 32'd1);
        while (!bif.RSP_VALID && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("add_latency", 32'(lat), 32'd7);
        check("add_c",   32'(bif.RSP_C), 32'h8);
        check("add_sf",  32'(bif.RSP_SF), 32'd1);
        check("add_zf",  32'(bif.RSP_ZF), 32'd0);
        check("add_cf",  32'(bif.RSP_CF), 32'd0);
        check("add_id",  32'(bif.RSP_ID), 32'd0);
        check("add_err", 32'(bif.RSP_ERR), 32'd0);
        bif.RSP_READY = 1'b1;
        @(negedge CLK);
        check("add_rsp_drop", 32'(bif.RSP_VALID), 32'd0);
        check("add_idle",     32'(bif.BUSY), 32'd0);
        bif.RSP_READY = 1'b0;

        // Reset in the third ISSUE cycle of an ADD.
        @(negedge CLK);
        drive_req0(1'b1, OP_ADD, 4'd7, 4'd1);
        @(posedge CLK);
        @(negedge CLK);
        bif.REQ0_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_pre_issue", 32'(bif.ALU_OPCODE), 32'(OP_ADD));
        RST = 1'b0;
        #1;
        check("rst_mid_opcode", 32'(bif.ALU_OPCODE), 32'd0);
        check("rst_mid_busy",   32'(bif.BUSY), 32'd0);
        check("rst_mid_state",  32'(st), 32'(ST_IDLE));
        check("rst_mid_alu_a",  32'(bif.ALU_A), 32'd0);
        check("rst_mid_alu_b",  32'(bif.ALU_B), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        saw = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            saw = saw | bif.RSP_VALID;
        end
        check("rst_no_rsp", 32'(saw), 32'd0);

        // Contention: XOR 5,5 on requester 0 and ADD 9,9 on requester 1, three each.
        for (int k = 0; k < 6; k++) begin
            exp_v = k[0] ? {1'b1, 4'h2, 1'b0, 1'b1} : {1'b0, 4'h0, 1'b1, 1'b0};
            exp_q.push_back(exp_v);
        end
        bif.RSP_READY = 1'b1;
        drive_req0(1'b1, OP_XOR, 4'd5, 4'd5);
        drive_req1(1'b1, OP_ADD, 4'd9, 4'd9);
        #1;
        check("alt_first_r0", 32'(bif.REQ0_READY), 32'd1);
        check("alt_first_r1", 32'(bif.REQ1_READY), 32'd0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                @(negedge CLK);
                #1;
            end
            n = 0;
            while (!(bif.REQ0_READY || bif.REQ1_READY) && n < 20) begin
                @(negedge CLK);
                #1;
                n++;
            end
            check("alt_grant_wait", 32'(n), 32'd0);
            check("alt_grant_id",   32'(bif.REQ1_READY), 32'(k % 2));
            @(posedge CLK);
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!bif.RSP_VALID && n < 20);
            check("alt_latency", 32'(n), 32'd7);
            exp_v = exp_q.pop_front();
            check("alt_rsp", 32'({bif.RSP_ID, bif.RSP_C, bif.RSP_ZF, bif.RSP_CF}), 32'(exp_v));
            if (k == 5) begin
                bif.REQ0_VALID = 1'b0;
                bif.REQ1_VALID = 1'b0;
            end
            @(posedge CLK);
        end
        check("alt_queue_empty", 32'(exp_q.size()), 32'd0);

        // Illegal opcode 110 from requester 1.
        @(negedge CLK);
        bif.RSP_READY = 1'b0;
        drive_req1(1'b1, 3'b110, 4'd1, 4'd2);
        #1;
        check("ill_ready1", 32'(bif.REQ1_READY), 32'd1);
        check("ill_ready0", 32'(bif.REQ0_READY), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        bif.REQ1_VALID = 1'b0;
        check("ill_valid",  32'(bif.RSP_VALID), 32'd1);
        check("ill_err",    32'(bif.RSP_ERR), 32'd1);
        check("ill_c",      32'(bif.RSP_C), 32'd0);
        check("ill_flags",  32'({bif.RSP_ZF, bif.RSP_SF, bif.RSP_CF}), 32'd0);
        check("ill_id",     32'(bif.RSP_ID), 32'd1);
        check("ill_opcode", 32'(bif.ALU_OPCODE), 32'd0);

        // Response back-pressure for 10 cycles with requester 0 waiting.
        drive_req0(1'b1, OP_ADD, 4'd1, 4'd1);
        stable = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            #1;
            if (!bif.RSP_VALID || !bif.RSP_ERR || bif.RSP_C != 4'd0 || !bif.RSP_ID || bif.REQ0_READY)
                stable = 1'b0;
        end
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_ready0", 32'(bif.REQ0_READY), 32'd0);
        check("stall_state",  32'(st), 32'(ST_RESP));
        bif.RSP_READY = 1'b1;
        @(negedge CLK);
        #1;
        check("stall_rsp_drop", 32'(bif.RSP_VALID), 32'd0);
        check("stall_accept",   32'(bif.REQ0_READY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bif.REQ0_VALID = 1'b0;
        n = 1;
        while (!bif.RSP_VALID && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("stall_next_lat", 32'(n), 32'd7);
        check("stall_next_c",   32'(bif.RSP_C), 32'h2);
        check("stall_next_id",  32'(bif.RSP_ID), 32'd0);
        check("stall_next_err", 32'(bif.RSP_ERR), 32'd0);
        @(posedge CLK);
        bif.RSP_READY = 1'b0;

        // ALU_LAT=1 instance: XNOR F,0.
        @(negedge CLK);
        bif1.REQ0_VALID = 1'b1; bif1.REQ0_OP = OP_XNOR; bif1.REQ0_A = 4'hF; bif1.REQ0_B = 4'h0;
        #1;
        check("l1_ready0", 32'(bif1.REQ0_READY), 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        bif1.REQ0_VALID = 1'b0;
        check("l1_issue_op", 32'(bif1.ALU_OPCODE), 32'(OP_XNOR));
        check("l1_t1_valid", 32'(bif1.RSP_VALID), 32'd0);
        @(negedge CLK);
        check("l1_cap_op",    32'(bif1.ALU_OPCODE), 32'(OP_HOLD));
        check("l1_cap_state", 32'(st1), 32'(ST_CAPTURE));
        check("l1_t2_valid",  32'(bif1.RSP_VALID), 32'd0);
        @(negedge CLK);
        check("l1_t3_valid", 32'(bif1.RSP_VALID), 32'd1);
        check("l1_c",        32'(bif1.RSP_C), 32'd0);
        check("l1_zf",       32'(bif1.RSP_ZF), 32'd1);
        check("l1_id",       32'(bif1.RSP_ID), 32'd0);
        bif1.RSP_READY = 1'b1;
        @(negedge CLK);
        check("l1_rsp_drop", 32'(bif1.RSP_VALID), 32'd0);
        bif1.RSP_READY = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
